// File: rtl/core_pkg.sv
// Shared rv32i core definitions: controller state encoding, PC width and alignment mask.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;
endpackage

// File: rtl/branch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  r_cnt <= '0;
    else if (clr_i)               r_cnt <= '0;
    else if (inc_i && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign cnt_o = r_cnt;
endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch/jump resolution: registered PC redirect over valid/ready,
// post-redirect flush window, misaligned-target pulse and statistics counters.
module branch_ctrl import core_pkg::*; #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ex_valid_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic             take_branch_i,
  input  logic [XLEN-1:0]  target_i,
  input  logic             fetch_ready_i,
  input  logic             clr_cnt_i,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             stall_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FW'(FLUSH_CYCLES - 1) : '0;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [FW-1:0]   r_fcnt;
  logic            r_misalign;

  logic w_idle, w_redir_ev, w_branch_ev, w_aligned, w_accept;

  // Inputs only matter in IDLE; the stage is flushed while we are busy.
  assign w_idle      = (r_state == IDLE);
  assign w_redir_ev  = w_idle && ex_valid_i && (jump_i || (branch_i && take_branch_i));
  assign w_branch_ev = w_idle && ex_valid_i && branch_i;
  assign w_aligned   = ((target_i[1:0] & ALIGN_MASK) == 2'b00);
  assign w_accept    = w_redir_ev && w_aligned;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_fcnt     <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_redir_ev && !w_aligned;
      case (r_state)
        IDLE: if (w_accept) begin
          r_pc    <= target_i;
          r_state <= REDIRECT;
        end
        REDIRECT: if (fetch_ready_i) begin
          if (FLUSH_CYCLES > 0) begin
            r_state <= FLUSH;
            r_fcnt  <= FLUSH_LOAD;
          end else begin
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          if (r_fcnt == '0) r_state <= IDLE;
          else              r_fcnt  <= r_fcnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign redirect_valid_o = (r_state == REDIRECT);
  assign redirect_pc_o    = r_pc;
  assign flush_o          = !w_idle;
  assign stall_o          = !w_idle;
  assign misalign_o       = r_misalign;

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_branch_ev),
    .clr_i  (clr_cnt_i),
    .cnt_o  (branch_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_accept),
    .clr_i  (clr_cnt_i),
    .cnt_o  (taken_cnt_o)
  );
endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized + directed bench for branch_ctrl against a transaction-level reference model.
module tb_branch_ctrl;
  localparam int XLEN  = 32;
  localparam int FC    = 2;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk, rst_n;
  logic             ex_valid, branch, jump, take;
  logic [XLEN-1:0]  target;
  logic             fetch_ready, clr_cnt;
  logic             redirect_valid, flush, stall, misalign;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt, taken_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: outstanding redirect, remaining flush cycles, counts.
  bit      m_pend;
  int      m_flush_rem;
  int      m_pc;
  bit      m_mis;
  int      m_bcnt, m_tcnt;
  int      n_redirects;

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .ex_valid_i       (ex_valid),
    .branch_i         (branch),
    .jump_i           (jump),
    .take_branch_i    (take),
    .target_i         (target),
    .fetch_ready_i    (fetch_ready),
    .clr_cnt_i        (clr_cnt),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .flush_o          (flush),
    .stall_o          (stall),
    .misalign_o       (misalign),
    .branch_cnt_o     (branch_cnt),
    .taken_cnt_o      (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream never presents a valid instruction while the controller is busy.
  always @(posedge clk) if (rst_n && stall) assert (!ex_valid);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_idle();
    return !m_pend && m_flush_rem == 0;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_flush_rem = 0; m_pc = 0; m_mis = 0; m_bcnt = 0; m_tcnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rv"},    redirect_valid, m_pend);
    chk({tag, ".pc"},    redirect_pc, m_pc);
    chk({tag, ".flush"}, flush, m_pend || m_flush_rem > 0);
    chk({tag, ".stall"}, stall, m_pend || m_flush_rem > 0);
    chk({tag, ".mis"},   misalign, m_mis);
    chk({tag, ".bcnt"},  branch_cnt, m_bcnt);
    chk({tag, ".tcnt"},  taken_cnt, m_tcnt);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic cyc(input string tag, input bit ev, input bit br, input bit jp, input bit tk,
                     input logic [31:0] tgt, input bit rdy, input bit clr);
    bit n_pend, n_mis, binc, tinc;
    int n_frem, n_pc;
    ex_valid = ev; branch = br; jump = jp; take = tk; target = tgt;
    fetch_ready = rdy; clr_cnt = clr;
    n_pend = m_pend; n_frem = m_flush_rem; n_pc = m_pc; n_mis = 0; binc = 0; tinc = 0;
    if (m_pend) begin
      if (rdy) begin n_pend = 0; n_frem = FC; n_redirects++; end
    end else if (m_flush_rem > 0) begin
      n_frem = m_flush_rem - 1;
    end else if (ev) begin
      binc = br;
      if (jp || (br && tk)) begin
        if (tgt % 4 == 0) begin n_pend = 1; n_pc = tgt; tinc = 1; end
        else n_mis = 1;
      end
    end
    @(posedge clk);
    m_pend = n_pend; m_flush_rem = n_frem; m_pc = n_pc; m_mis = n_mis;
    if (clr) begin m_bcnt = 0; m_tcnt = 0; end
    else begin
      if (binc && m_bcnt < CMAX) m_bcnt++;
      if (tinc && m_tcnt < CMAX) m_tcnt++;
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 32'h0, 1, 0);
  endtask

  initial begin
    rst_n = 0; ex_valid = 0; branch = 0; jump = 0; take = 0; target = '0;
    fetch_ready = 0; clr_cnt = 0; n_redirects = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1;

    // Taken BEQ to 0x100, fetch ready: redirect at N+1, flush N+1..N+3, idle at N+4.
    cyc("beq", 1, 1, 0, 1, 32'h100, 1, 0);
    chk("beq.rv_n1", redirect_valid, 1);
    chk("beq.pc_n1", redirect_pc, 32'h100);
    idle_cycles("beq_fl", 2);
    chk("beq.flush_n3", flush, 1);
    idle_cycles("beq_done", 1);
    chk("beq.stall_n4", stall, 0);
    chk("beq.tcnt", taken_cnt, 1);
    chk("beq.bcnt", branch_cnt, 1);

    // Taken branch held off by fetch for 3 cycles.
    cyc("bp", 1, 1, 0, 1, 32'h4440, 0, 0);
    for (int i = 0; i < 3; i++) cyc("bp_wait", 0, 0, 0, 0, 32'h0, 0, 0);
    cyc("bp_hs", 0, 0, 0, 0, 32'h0, 1, 0);
    idle_cycles("bp_fl", 3);
    chk("bp.tcnt", taken_cnt, 2);

    // Not-taken BNE then JAL to 0x200.
    clr_cnt = 1; cyc("clr", 0, 0, 0, 0, 32'h0, 0, 1);
    n_redirects = 0;
    cyc("bne", 1, 1, 0, 0, 32'h999, 1, 0);
    cyc("jal", 1, 0, 1, 0, 32'h200, 1, 0);
    chk("jal.pc", redirect_pc, 32'h200);
    idle_cycles("jal_fl", 4);
    chk("jal.bcnt", branch_cnt, 1);
    chk("jal.tcnt", taken_cnt, 1);
    chk("jal.nredir", n_redirects, 1);

    // Misaligned JALR.
    cyc("jalr", 1, 0, 1, 0, 32'h102, 1, 0);
    chk("jalr.mis", misalign, 1);
    chk("jalr.rv", redirect_valid, 0);
    idle_cycles("jalr_after", 2);
    chk("jalr.tcnt", taken_cnt, 1);

    // Reset asserted mid-REDIRECT.
    cyc("rst_br", 1, 1, 0, 1, 32'h300, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("rst_mid");
    @(posedge clk); #1 rst_n = 1;
    idle_cycles("rst_after", 4);

    // Saturation: drive counters to all-ones, then clear alongside a taken branch.
    for (int i = 0; i < CMAX + 3; i++) begin
      cyc("sat_br", 1, 1, 0, 1, 32'h1000 + 4 * i, 1, 0);
      idle_cycles("sat_fl", FC + 1);
    end
    chk("sat.bcnt", branch_cnt, CMAX);
    chk("sat.tcnt", taken_cnt, CMAX);
    cyc("sat_clr", 1, 1, 0, 1, 32'h2000, 1, 1);
    chk("sat_clr.bcnt", branch_cnt, 0);
    chk("sat_clr.tcnt", taken_cnt, 0);
    idle_cycles("sat_clr_fl", FC + 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit ev, br, jp, tk, rdy, clr;
      logic [31:0] tgt;
      ev  = m_idle() && ($urandom_range(0, 2) != 0);
      br  = $urandom_range(0, 1);
      jp  = ($urandom_range(0, 3) == 0);
      tk  = $urandom_range(0, 1);
      tgt = $urandom;
      if ($urandom_range(0, 5) != 0) tgt[1:0] = 2'b00;
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 60) == 0);
      cyc("rnd", ev, br, jp, tk, tgt, rdy, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences branch/jump resolution in the EX stage of the rv32i core.
- Consumes the taken/not-taken result of the branch compare unit plus the computed target.
- Issues a PC redirect to fetch over a valid/ready handshake, then flushes younger stages for a configurable number of cycles.
- Raises instruction-address-misaligned and keeps saturating branch statistics counters.

Parameters:
- XLEN, 32, width of PC and target
- FLUSH_CYCLES, 2, cycles flush_o stays high after the redirect handshake (0 allowed)
- CNT_W, 16, width of statistics counters

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- ex_valid_i  in  1  valid instruction in EX this cycle
- branch_i  in  1  EX instruction is a conditional branch
- jump_i  in  1  EX instruction is JAL/JALR (unconditional)
- take_branch_i  in  1  compare result for the EX branch
- target_i  in  XLEN  branch/jump target address
- fetch_ready_i  in  1  fetch accepts redirect this cycle
- clr_cnt_i  in  1  synchronous clear of statistics counters
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  XLEN  redirect address (registered)
- flush_o  out  1  kill IF/ID contents
- stall_o  out  1  freeze PC/IF/ID while controller busy
- misalign_o  out  1  one-cycle pulse: taken target not 4-byte aligned
- branch_cnt_o  out  CNT_W  conditional branches resolved
- taken_cnt_o  out  CNT_W  control transfers redirected (taken branches + jumps)

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE.
  - All outputs 0.
  - redirect_pc_o=0 and both counters=0.
  - Asserting reset mid-REDIRECT/FLUSH aborts immediately; no redirect is issued after release.
- States: IDLE, REDIRECT, FLUSH. All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- Event definitions:
  - "redirect event": IDLE && ex_valid_i && (jump_i || (branch_i && take_branch_i)).
  - "branch event": IDLE && ex_valid_i && branch_i.
- IDLE:
  - Redirect event with target_i[1:0]==0:
    - latch target_i into redirect_pc_o;
    - next state REDIRECT;
    - redirect_valid_o=1 in cycle N+1 (one-cycle latency).
  - Redirect event with target_i[1:0]!=0:
    - misalign_o=1 in cycle N+1 for exactly one cycle;
    - no redirect is issued, redirect_pc_o is unchanged, and the state stays IDLE;
    - the taken counter is not incremented.
  - Not-taken branch or non-control instruction: no action except the branch counter update.
- REDIRECT:
  - redirect_valid_o=1, flush_o=1, stall_o=1.
  - redirect_pc_o is held stable until the handshake.
  - Handshake: redirect_valid_o && fetch_ready_i. On handshake:
    - if FLUSH_CYCLES>0, go to FLUSH and load the counter with FLUSH_CYCLES-1;
    - otherwise go to IDLE.
  - redirect_valid_o drops the cycle after the handshake.
- FLUSH:
  - flush_o=1, stall_o=1, redirect_valid_o=0.
  - The counter decrements each cycle; when the counter==0, go to IDLE.
  - Total flush_o-high cycles after the handshake = FLUSH_CYCLES.
- While not IDLE, ex_valid_i/branch_i/jump_i are ignored: no counting and no new redirect.
  - Upstream guarantees ex_valid_i=0 there (the stage is flushed); the bench asserts this.
- Counters:
  - branch_cnt_o increments on each branch event.
  - taken_cnt_o increments on each accepted (aligned) redirect event.
  - Both saturate at all-ones.
  - clr_cnt_i zeroes both next cycle and wins over a simultaneous increment.
- A jump with branch_i=1 is treated as a jump; the branch counter still counts it.
- Targets are used verbatim. JALR bit-0 clearing is done upstream.

Decomposition:
- Shared package core_pkg holds:
  - the state typedef (IDLE/REDIRECT/FLUSH) and XLEN;
  - the constant ALIGN_MASK=2'b11.
- One natural sub-module: sat_counter (CNT_W, inc, clr, saturate), instantiated twice for the statistics.

Test Plan:
- Taken BEQ, target 0x0000_0100, fetch_ready_i=1:
  - redirect_valid_o=1 with pc 0x100 at N+1;
  - flush_o high for N+1..N+3 (FLUSH_CYCLES=2);
  - stall_o low at N+4;
  - taken_cnt=1, branch_cnt=1.
- Taken branch with fetch_ready_i=0 for 3 cycles:
  - redirect_valid_o and redirect_pc_o stay stable for 4 cycles;
  - FLUSH follows the handshake;
  - a single taken_cnt increment.
- Not-taken BNE, then JAL to 0x200: branch_cnt=1, taken_cnt=1, exactly one redirect (0x200).
- JALR target 0x0000_0102: misalign_o one-cycle pulse, no redirect_valid_o, state IDLE, taken_cnt unchanged.
- rst_ni low during REDIRECT: all outputs 0 immediately; after release no redirect_valid_o and counters are 0.
- Counters at 0xFFFF plus taken branch → stay 0xFFFF; clr_cnt_i together with a taken branch → both counters 0.
